// File: rtl/pla_share_pkg.sv
// Shared constants for the PLA sharing controller: PLA vector widths and
// default requester count / result buffer depth.
package pla_share_pkg;

  localparam int unsigned PLA_IN_W       = 83;
  localparam int unsigned PLA_OUT_W      = 94;
  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: picks the first valid requester at or after
// rr_ptr, wrapping modulo NUM_REQ. Purely combinational.
module rr_arbiter
  import pla_share_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               enable,
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [IDX_W-1:0]   idx_c
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan from rr_ptr upward; the first hit wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (enable && !found && valid[cand]) begin
        found         = 1'b1;
        grant_c[cand] = 1'b1;
        idx_c         = cand;
      end
    end
  end

endmodule

// File: rtl/pla_share_ctrl.sv
// Time-shares one external combinational PLA among NUM_REQ requesters:
// round-robin accept, one-cycle evaluation stage, in-order result buffer.
module pla_share_ctrl
  import pla_share_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter  int unsigned IN_W       = PLA_IN_W,
  parameter  int unsigned OUT_W      = PLA_OUT_W,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [IN_W-1:0]         pla_in,
  input  logic [OUT_W-1:0]        pla_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDX_W-1:0]        rsp_id,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IN_W-1:0]  pla_in_q, pla_in_d;
  logic             stg_vld_q, stg_vld_d;
  logic [IDX_W-1:0] stg_id_q, stg_id_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] id_mem_q   [FIFO_DEPTH];
  logic [IDX_W-1:0] id_mem_d   [FIFO_DEPTH];
  logic [OUT_W-1:0] data_mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0] data_mem_d [FIFO_DEPTH];

  logic [IN_W-1:0]    req_vec [NUM_REQ];
  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   gnt_idx_c;
  logic               space_c;
  logic               xfer_c;
  logic               push_c;
  logic               pop_c;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_vec[g] = req_data[g*IN_W +: IN_W];
  end

  // The in-flight stage reserves a buffer slot so a push can never overflow.
  assign space_c = (OCC_W'(cnt_q) + OCC_W'(stg_vld_q)) < OCC_W'(FIFO_DEPTH);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .enable  (space_c & ~rst),
    .valid   (req_valid),
    .rr_ptr  (rr_ptr_q),
    .grant_c (grant_c),
    .idx_c   (gnt_idx_c)
  );

  assign req_ready = grant_c;
  assign xfer_c    = |(req_valid & grant_c);
  assign push_c    = stg_vld_q;
  assign rsp_valid = (cnt_q != '0);
  assign pop_c     = rsp_valid & rsp_ready;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    pla_in_d   = pla_in_q;
    stg_vld_d  = xfer_c;
    stg_id_d   = stg_id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    id_mem_d   = id_mem_q;
    data_mem_d = data_mem_q;
    if (xfer_c) begin
      pla_in_d = req_vec[gnt_idx_c];
      stg_id_d = gnt_idx_c;
      rr_ptr_d = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
    end
    // The PLA result for last cycle's accept is valid now; capture it.
    if (push_c) begin
      id_mem_d[wr_ptr_q]   = stg_id_q;
      data_mem_d[wr_ptr_q] = pla_out;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      pla_in_q  <= '0;
      stg_vld_q <= 1'b0;
      stg_id_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pla_in_q  <= pla_in_d;
      stg_vld_q <= stg_vld_d;
      stg_id_q  <= stg_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Buffer storage needs no reset; its contents are masked while empty.
  always_ff @(posedge clk) begin
    id_mem_q   <= id_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign pla_in   = pla_in_q;
  assign rsp_id   = rsp_valid ? id_mem_q[rd_ptr_q]   : '0;
  assign rsp_data = rsp_valid ? data_mem_q[rd_ptr_q] : '0;
  assign busy     = stg_vld_q | rsp_valid;

endmodule

// File: tb/tb_pla_share_ctrl.sv
// Self-checking bench for pla_share_ctrl with a behavioural PLA model and
// an in-order scoreboard keyed on accepted requests.
module tb_pla_share_ctrl;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned IN_W       = 83;
  localparam int unsigned OUT_W      = 94;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned IDX_W      = 2;

  typedef struct {
    int               id;
    logic [OUT_W-1:0] data;
  } exp_t;

  logic                    clk;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*IN_W-1:0] req_data;
  logic [IN_W-1:0]         pla_in;
  logic [OUT_W-1:0]        pla_out;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDX_W-1:0]        rsp_id;
  logic [OUT_W-1:0]        rsp_data;
  logic                    busy;

  exp_t sb_q[$];
  int   acc_log[$];
  int   rsp_log[$];
  int   n_checks;
  int   n_fail;
  logic             stall_prev;
  logic [IDX_W-1:0] hold_id;
  logic [OUT_W-1:0] hold_data;

  pla_share_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .pla_in    (pla_in),
    .pla_out   (pla_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Stand-in for the external PLA; z01 is the complement of x00.
  function automatic logic [OUT_W-1:0] pla_model(input logic [IN_W-1:0] x);
    logic [OUT_W-1:0] z;
    for (int k = 0; k < OUT_W; k++)
      z[k] = x[k % IN_W] ^ (x[(3*k+1) % IN_W] & x[(5*k+2) % IN_W]);
    z[0] = x[0] | x[IN_W-1];
    z[1] = ~x[0];
    return z;
  endfunction

  function automatic logic [IN_W-1:0] rand_vec();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[IN_W-1:0];
  endfunction

  assign pla_out = pla_model(pla_in);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: sample mid-cycle, score handshakes, then step past the edge.
  task automatic clock_cycle();
    int   acc_now;
    exp_t e;
    @(negedge clk);
    acc_now = -1;
    n_checks++;
    if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
      n_fail++;
      $display("FAIL ready_onehot: req_ready=%b req_valid=%b, required at most one bit and only on a valid requester",
               req_ready, req_valid);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = i;
        e.data = pla_model(req_data[i*IN_W +: IN_W]);
        sb_q.push_back(e);
        acc_log.push_back(i);
        acc_now = i;
      end
    end
    if (!rst && stall_prev) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_data !== hold_data) begin
        n_fail++;
        $display("FAIL rsp_hold: valid=%b id=%0d data=%h, required valid=1 id=%0d data=%h",
                 rsp_valid, rsp_id, rsp_data, hold_id, hold_data);
      end
    end
    stall_prev = !rst && rsp_valid && !rsp_ready;
    hold_id    = rsp_id;
    hold_data  = rsp_data;
    if (rsp_valid && rsp_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: id=%0d data=%h, required no response", rsp_id, rsp_data);
      end else begin
        e = sb_q.pop_front();
        rsp_log.push_back(int'(rsp_id));
        if (rsp_id !== IDX_W'(e.id) || rsp_data !== e.data) begin
          n_fail++;
          $display("FAIL rsp_data: id=%0d data=%h, required id=%0d data=%h",
                   rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
    @(posedge clk);
    #1;
    if (acc_now >= 0) req_data[acc_now*IN_W +: IN_W] = rand_vec();
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc       = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((sb_q.size() != 0 || busy !== 1'b0) && cyc < 50) begin
      clock_cycle();
      cyc++;
    end
    n_checks++;
    if (sb_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: pending=%0d busy=%b, required pending=0 busy=0", tag, sb_q.size(), busy);
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    sb_q.delete();
    stall_prev = 1'b0;
    rst        = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 5;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: %b, required 0", rsp_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: %b, required 0", busy); end
    if (req_ready !== '0)   begin n_fail++; $display("FAIL reset_req_ready: %b, required 0000", req_ready); end
    if (pla_in !== '0)      begin n_fail++; $display("FAIL reset_pla_in: %h, required 0", pla_in); end
    if (rsp_id !== '0)      begin n_fail++; $display("FAIL reset_rsp_id: %0d, required 0", rsp_id); end
    req_valid = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single();
    logic [IN_W-1:0] v;
    int base;
    base      = acc_log.size();
    v         = rand_vec();
    v[0]      = 1'b0;
    req_data[2*IN_W +: IN_W] = v;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    clock_cycle();
    req_valid = '0;
    n_checks += 3;
    if (acc_log.size() != base + 1) begin
      n_fail++;
      $display("FAIL single_first_accept: accepts=%0d, required 1", acc_log.size() - base);
    end
    if (pla_in !== v)       begin n_fail++; $display("FAIL single_pla_in: %h, required %h", pla_in, v); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: rsp_valid=%b, required 0", rsp_valid); end
    clock_cycle();
    n_checks += 3;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: %b, required 1", rsp_valid); end
    if (rsp_id !== 2'd2)    begin n_fail++; $display("FAIL single_rsp_id: %0d, required 2", rsp_id); end
    if (rsp_data[1] !== 1'b1) begin n_fail++; $display("FAIL single_z01: %b, required 1", rsp_data[1]); end
    clock_cycle();
    n_checks++;
    if (rsp_valid !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_after_pop: rsp_valid=%b pending=%0d, required 0 and 0", rsp_valid, sb_q.size());
    end
  endtask

  task automatic test_fairness();
    int base;
    int rbase;
    apply_reset();
    base      = acc_log.size();
    rbase     = rsp_log.size();
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (5) clock_cycle();
    drain("fair");
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (acc_log.size() <= base + k || acc_log[base+k] != k % NUM_REQ) begin
        n_fail++;
        $display("FAIL fair_grant_%0d: got %0d, required %0d", k,
                 (acc_log.size() > base + k) ? acc_log[base+k] : -1, k % NUM_REQ);
      end
      n_checks++;
      if (rsp_log.size() <= rbase + k || rsp_log[rbase+k] != k % NUM_REQ) begin
        n_fail++;
        $display("FAIL fair_rsp_%0d: got %0d, required %0d", k,
                 (rsp_log.size() > rbase + k) ? rsp_log[rbase+k] : -1, k % NUM_REQ);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    base      = acc_log.size();
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (8) clock_cycle();
    n_checks += 3;
    if (acc_log.size() - base != 4) begin
      n_fail++;
      $display("FAIL bp_accepts: %0d, required 4", acc_log.size() - base);
    end
    if (req_ready !== '0)   begin n_fail++; $display("FAIL bp_ready_low: %b, required 0000", req_ready); end
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid: %b, required 1", rsp_valid); end
    rsp_ready = 1'b1;
    repeat (6) clock_cycle();
    n_checks++;
    if (acc_log.size() - base <= 4) begin
      n_fail++;
      $display("FAIL bp_resume: accepts=%0d, required more than 4", acc_log.size() - base);
    end
    drain("bp");
  endtask

  task automatic test_push_pop();
    int base;
    int rbase;
    base      = acc_log.size();
    rbase     = rsp_log.size();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (4) clock_cycle();
    n_checks++;
    if (acc_log.size() - base != 4) begin
      n_fail++;
      $display("FAIL pp_fill: accepts=%0d, required 4", acc_log.size() - base);
    end
    // Buffer holds 3 with one in flight: this cycle pushes and pops together.
    req_valid = '0;
    rsp_ready = 1'b1;
    clock_cycle();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL pp_count3_ready: %b, required 0010", req_ready); end
    clock_cycle();
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL pp_full_ready: %b, required 0000", req_ready); end
    drain("pp");
    n_checks++;
    if (rsp_log.size() - rbase != 5) begin
      n_fail++;
      $display("FAIL pp_rsp_count: %0d, required 5", rsp_log.size() - rbase);
    end
  endtask

  task automatic test_reset_mid();
    int rbase;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    repeat (3) clock_cycle();
    n_checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_setup: rsp_valid=%b busy=%b, required 1 1", rsp_valid, busy);
    end
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_rsp_valid: %b, required 0", rsp_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL rm_busy: %b, required 0", busy); end
    if (req_ready !== '0)   begin n_fail++; $display("FAIL rm_req_ready: %b, required 0000", req_ready); end
    if (rsp_id !== '0)      begin n_fail++; $display("FAIL rm_rsp_id: %0d, required 0", rsp_id); end
    if (pla_in !== '0)      begin n_fail++; $display("FAIL rm_pla_in: %h, required 0", pla_in); end
    sb_q.delete();
    stall_prev = 1'b0;
    clock_cycle();
    req_valid = '0;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    rbase     = rsp_log.size();
    repeat (5) clock_cycle();
    n_checks++;
    if (rsp_log.size() != rbase || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_stale: responses=%0d rsp_valid=%b busy=%b, required 0 0 0",
               rsp_log.size() - rbase, rsp_valid, busy);
    end
  endtask

  task automatic test_wrap();
    int base;
    int rbase;
    base      = acc_log.size();
    rbase     = rsp_log.size();
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (10) clock_cycle();
    n_checks++;
    if (acc_log.size() - base != 10) begin
      n_fail++;
      $display("FAIL wrap_back_to_back: accepts=%0d, required 10", acc_log.size() - base);
    end
    drain("wrap");
    n_checks++;
    if (rsp_log.size() - rbase != 10) begin
      n_fail++;
      $display("FAIL wrap_rsp_count: %0d, required 10", rsp_log.size() - rbase);
    end
    repeat (60) begin
      req_valid = NUM_REQ'($urandom_range(0, 15));
      rsp_ready = 1'($urandom_range(0, 1));
      clock_cycle();
    end
    drain("random");
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    stall_prev = 1'b0;
    hold_id    = '0;
    hold_data  = '0;
    rst        = 1'b0;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*IN_W +: IN_W] = rand_vec();
    #2 rst = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
